// File: rtl/core_rx_mon_pkg.sv
// Shared types and constants for the receive monitor: lock-state encoding,
// CPU register map, control-register bit positions and counter width.
// Pure declarations, no logic; imported by every core_rx_monitor file.
package core_rx_mon_pkg;

  // Encoding is visible to software through the status register.
  typedef enum logic [1:0] {
    ST_LOSS    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2
  } rx_state_e;

  localparam logic [4:0] REG_STATUS   = 5'h00;
  localparam logic [4:0] REG_ERR_LO   = 5'h01;
  localparam logic [4:0] REG_ERR_HI   = 5'h02;
  localparam logic [4:0] REG_FIFO_CNT = 5'h03;
  localparam logic [4:0] REG_CTRL     = 5'h04;
  localparam logic [4:0] REG_SYM_LO   = 5'h05;
  localparam logic [4:0] REG_SYM_HI   = 5'h06;

  localparam int CTRL_CLR_BIT   = 0;  // clear err_cnt, rx_overflow (and sym_cnt)
  localparam int CTRL_FLUSH_BIT = 1;  // empty the data FIFO

  localparam int CNT_W = 16;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/core_rx_monitor_if.sv
// Bundle of decoder symbol inputs, CPU register bus and the rx data stream.
// master = symbol source / CPU / consumer side, slave = core_rx_monitor.
// Signals: core_data/core_code_error/core_code_idle, cpu_wr/addr/wdata/rdata,
//          rx_data/rx_valid/rx_ready, link_up, rx_overflow.
interface core_rx_monitor_if;
  logic [7:0] core_data;
  logic       core_code_error;
  logic       core_code_idle;
  logic       cpu_wr;
  logic [4:0] cpu_addr;
  logic [7:0] cpu_wdata;
  logic [7:0] cpu_rdata;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       link_up;
  logic       rx_overflow;

  modport master (
    output core_data, core_code_error, core_code_idle,
    output cpu_wr, cpu_addr, cpu_wdata, rx_ready,
    input  cpu_rdata, rx_data, rx_valid, link_up, rx_overflow
  );

  modport slave (
    input  core_data, core_code_error, core_code_idle,
    input  cpu_wr, cpu_addr, cpu_wdata, rx_ready,
    output cpu_rdata, rx_data, rx_valid, link_up, rx_overflow
  );
endinterface

// File: rtl/core_rx_fifo.sv
// Synchronous 8-bit FIFO, DEPTH entries (power of 2, >= 2), no fall-through.
// Latency: pushed data visible at the head one cycle after the push edge.
// Backpressure: push when full is ignored unless a pop happens in the same cycle; flush wins.
// Ports: push/wdata in, pop, flush, rdata (head), empty, full, count.
module core_rx_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [7:0]               wdata,
  output logic [7:0]               rdata,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop frees the slot this same edge, so a full FIFO can still accept.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
endmodule

// File: rtl/core_rx_monitor.sv
// Link-lock FSM, saturating error counter and data FIFO behind the symbol decoder.
// Latency: data symbol to rx_valid 1 cycle; link_up registered with the FSM state.
// Backpressure: rx_ready stalls the FIFO; symbols arriving while full are dropped (sticky rx_overflow).
// Ports: clock, reset (async, active-high), bus (core_rx_monitor_if.slave).
// Option: CORE_RX_MON_STATS_EN adds a pushed-symbol counter at 0x05/0x06.
module core_rx_monitor
  import core_rx_mon_pkg::*;
#(
  parameter int SYNC_IDLES = 8,
  parameter int ERR_WINDOW = 64,
  parameter int ERR_THRESH = 4,
  parameter int FIFO_DEPTH = 16
) (
  input  logic               clock,
  input  logic               reset,
  core_rx_monitor_if.slave   bus
);
  localparam int IDLE_W = $clog2(SYNC_IDLES + 1);
  localparam int WIN_W  = $clog2(ERR_WINDOW);
  localparam int ERR_W  = $clog2(ERR_THRESH + 1);
  localparam int FCW    = $clog2(FIFO_DEPTH) + 1;

  rx_state_e         state, state_nxt;
  logic [IDLE_W-1:0] idle_cnt, idle_nxt, idle_inc;
  logic [WIN_W-1:0]  win_cnt, win_nxt;
  logic [ERR_W-1:0]  win_err, werr_nxt, err_sum;
  logic              link_up_q;
  logic [CNT_W-1:0]  err_cnt;
  logic              ovf_q;

  // An error flag overrides a simultaneous idle flag.
  logic is_err, is_idle, is_data;
  assign is_err  = bus.core_code_error;
  assign is_idle = bus.core_code_idle && !bus.core_code_error;
  assign is_data = !bus.core_code_idle && !bus.core_code_error;

  logic ctrl_wr, clr, flush;
  assign ctrl_wr = bus.cpu_wr && (bus.cpu_addr == REG_CTRL);
  assign clr     = ctrl_wr && bus.cpu_wdata[CTRL_CLR_BIT];
  assign flush   = ctrl_wr && bus.cpu_wdata[CTRL_FLUSH_BIT];

  always_comb begin
    state_nxt = state;
    idle_nxt  = idle_cnt;
    win_nxt   = win_cnt;
    werr_nxt  = win_err;
    idle_inc  = idle_cnt + IDLE_W'(1);
    err_sum   = win_err + ERR_W'(is_err);
    case (state)
      ST_LOSS: begin
        if (is_idle) begin
          state_nxt = ST_ACQUIRE;
          idle_nxt  = IDLE_W'(1);
        end
      end
      ST_ACQUIRE: begin
        if (is_idle) begin
          idle_nxt = idle_inc;
          if (idle_inc == IDLE_W'(SYNC_IDLES)) begin
            state_nxt = ST_LOCKED;
            idle_nxt  = '0;
            win_nxt   = '0;
            werr_nxt  = '0;
          end
        end else begin
          state_nxt = ST_LOSS;
          idle_nxt  = '0;
        end
      end
      ST_LOCKED: begin
        // Threshold check includes this cycle's error and beats the window wrap.
        if (err_sum >= ERR_W'(ERR_THRESH)) begin
          state_nxt = ST_LOSS;
          win_nxt   = '0;
          werr_nxt  = '0;
        end else if (win_cnt == WIN_W'(ERR_WINDOW - 1)) begin
          win_nxt  = '0;
          werr_nxt = '0;
        end else begin
          win_nxt  = win_cnt + WIN_W'(1);
          werr_nxt = err_sum;
        end
      end
      default: state_nxt = ST_LOSS;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= ST_LOSS;
      idle_cnt  <= '0;
      win_cnt   <= '0;
      win_err   <= '0;
      link_up_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      idle_cnt  <= idle_nxt;
      win_cnt   <= win_nxt;
      win_err   <= werr_nxt;
      link_up_q <= (state_nxt == ST_LOCKED);
    end
  end

  // FIFO path
  logic           push, pop, fifo_empty, fifo_full, push_ok;
  logic [FCW-1:0] fifo_count;

  assign push    = (state == ST_LOCKED) && is_data;
  assign pop     = bus.rx_valid && bus.rx_ready;
  assign push_ok = push && (!fifo_full || pop) && !flush;

  core_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata (bus.core_data),
    .rdata (bus.rx_data),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err_cnt <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (clr)         err_cnt <= '0;
      else if (is_err) err_cnt <= sat_inc(err_cnt);
      // A flushed push never lands, so it cannot overflow either.
      if (clr)                                     ovf_q <= 1'b0;
      else if (push && fifo_full && !pop && !flush) ovf_q <= 1'b1;
    end
  end

`ifdef CORE_RX_MON_STATS_EN
  logic [CNT_W-1:0] sym_cnt;
  always_ff @(posedge clock or posedge reset) begin
    if (reset)        sym_cnt <= '0;
    else if (clr)     sym_cnt <= '0;
    else if (push_ok) sym_cnt <= sat_inc(sym_cnt);
  end
`else
  logic unused_push_ok;
  assign unused_push_ok = push_ok;
`endif

  assign bus.rx_valid    = !fifo_empty;
  assign bus.link_up     = link_up_q;
  assign bus.rx_overflow = ovf_q;

  always_comb begin
    bus.cpu_rdata = 8'h00;
    case (bus.cpu_addr)
      REG_STATUS:   bus.cpu_rdata = {5'b0, ovf_q, 2'(state)};
      REG_ERR_LO:   bus.cpu_rdata = err_cnt[7:0];
      REG_ERR_HI:   bus.cpu_rdata = err_cnt[15:8];
      REG_FIFO_CNT: bus.cpu_rdata = 8'(fifo_count);
`ifdef CORE_RX_MON_STATS_EN
      REG_SYM_LO:   bus.cpu_rdata = sym_cnt[7:0];
      REG_SYM_HI:   bus.cpu_rdata = sym_cnt[15:8];
`endif
      default:      bus.cpu_rdata = 8'h00;
    endcase
  end
endmodule

// File: tb/tb_core_rx_monitor.sv
// Self-checking bench for core_rx_monitor: lock/loss FSM, error counter,
// FIFO ordering/overflow, control register clear/flush and async reset.
// Data symbols are queued on the scoreboard when driven and checked on pop.
module tb_core_rx_monitor;
  import core_rx_mon_pkg::*;

  localparam int K_DATA = 0;
  localparam int K_IDLE = 1;
  localparam int K_ERR  = 2;
  localparam int K_BOTH = 3;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #50 clock = ~clock;

  core_rx_monitor_if bus();

  core_rx_monitor #(
    .SYNC_IDLES (8),
    .ERR_WINDOW (64),
    .ERR_THRESH (4),
    .FIFO_DEPTH (16)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] sb_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one symbol, let it be clocked, return just after the edge.
  task automatic sym(input int kind, input logic [7:0] d);
    bus.core_data       = d;
    bus.core_code_idle  = (kind == K_IDLE) || (kind == K_BOTH);
    bus.core_code_error = (kind == K_ERR)  || (kind == K_BOTH);
    @(posedge clock);
    #1;
  endtask

  task automatic syms(input int kind, input int n);
    repeat (n) sym(kind, 8'h00);
  endtask

  // Data symbol that the bench expects to land in the FIFO.
  task automatic push_data(input logic [7:0] d);
    sb_q.push_back(d);
    sym(K_DATA, d);
  endtask

  task automatic chk_reg(input string tag, input logic [4:0] a, input logic [7:0] exp);
    bus.cpu_addr = a;
    #1;
    chk(tag, bus.cpu_rdata, exp);
  endtask

  task automatic wr_sym(input logic [4:0] a, input logic [7:0] wd, input int kind, input logic [7:0] d);
    bus.cpu_wr    = 1'b1;
    bus.cpu_addr  = a;
    bus.cpu_wdata = wd;
    sym(kind, d);
    bus.cpu_wr    = 1'b0;
  endtask

  // Scoreboard: every accepted pop must match the oldest expected symbol.
  always @(negedge clock) begin
    if (!reset && bus.rx_valid && bus.rx_ready) begin
      chk("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) chk("rx_data", bus.rx_data, sb_q.pop_front());
    end
  end

  initial begin
    bus.core_data       = 8'h00;
    bus.core_code_error = 1'b0;
    bus.core_code_idle  = 1'b0;
    bus.cpu_wr          = 1'b0;
    bus.cpu_addr        = 5'h00;
    bus.cpu_wdata       = 8'h00;
    bus.rx_ready        = 1'b0;
    repeat (3) @(posedge clock);
    #1;

    // Reset state
    chk("rst_link_up", bus.link_up, 1'b0);
    chk("rst_rx_valid", bus.rx_valid, 1'b0);
    chk("rst_overflow", bus.rx_overflow, 1'b0);
    chk_reg("rst_status", REG_STATUS, 8'h00);
    chk_reg("rst_err_lo", REG_ERR_LO, 8'h00);
    chk_reg("rst_fifo_cnt", REG_FIFO_CNT, 8'h00);
    chk_reg("rst_unmapped", 5'h1F, 8'h00);
    reset = 1'b0;

    // 7 idles then data: acquisition aborted
    syms(K_IDLE, 7);
    chk_reg("acq_state_7idle", REG_STATUS, 8'h01);
    chk("acq_link_7idle", bus.link_up, 1'b0);
    sym(K_DATA, 8'hAA);
    chk_reg("acq_abort_state", REG_STATUS, 8'h00);
    chk("acq_abort_link", bus.link_up, 1'b0);
    chk("acq_data_discarded", bus.rx_valid, 1'b0);

    // 8 idles: lock right after the 8th
    syms(K_IDLE, 7);
    chk("lock_not_yet", bus.link_up, 1'b0);
    sym(K_IDLE, 8'h00);
    chk("lock_link_up", bus.link_up, 1'b1);
    chk_reg("lock_state", REG_STATUS, 8'h02);

    // 4 errors inside one window drop the lock
    sym(K_ERR, 8'h00);
    sym(K_IDLE, 8'h00);
    sym(K_ERR, 8'h00);
    sym(K_ERR, 8'h00);
    chk("loss_3err_locked", bus.link_up, 1'b1);
    sym(K_ERR, 8'h00);
    chk("loss_link_down", bus.link_up, 1'b0);
    chk_reg("loss_state", REG_STATUS, 8'h00);
    chk_reg("loss_err_lo", REG_ERR_LO, 8'h04);
    chk_reg("loss_err_hi", REG_ERR_HI, 8'h00);

    // Error wins over idle: no acquisition, counted as error
    sym(K_BOTH, 8'h00);
    chk_reg("prio_state", REG_STATUS, 8'h00);
    chk_reg("prio_err_lo", REG_ERR_LO, 8'h05);

    // Clear wins over a same-cycle error increment
    wr_sym(REG_CTRL, 8'h01, K_ERR, 8'h00);
    chk_reg("clr_wins_err_lo", REG_ERR_LO, 8'h00);
    chk_reg("clr_wins_err_hi", REG_ERR_HI, 8'h00);

    // Window wrap resets the per-window error tally
    syms(K_IDLE, 8);
    chk("win_relock", bus.link_up, 1'b1);
    syms(K_ERR, 3);          // symbols 0..2 of the first window
    syms(K_IDLE, 61);        // symbols 3..63
    chk_reg("win_still_locked", REG_STATUS, 8'h02);
    syms(K_ERR, 2);          // symbols 64..65, second window
    chk("win_reset_link", bus.link_up, 1'b1);
    chk_reg("win_err_lo", REG_ERR_LO, 8'h05);
    wr_sym(REG_CTRL, 8'h01, K_IDLE, 8'h00);

    // Overflow: 17 pushes into 16 entries, head never consumed
    bus.rx_ready = 1'b0;
    chk("ovf_start_empty", bus.rx_valid, 1'b0);
    push_data(8'h10);
    chk("push_latency", bus.rx_valid, 1'b1);
    for (int i = 1; i < 16; i++) push_data(8'(8'h10 + i));
    chk_reg("ovf_cnt_full", REG_FIFO_CNT, 8'd16);
    chk_reg("ovf_not_yet", REG_STATUS, 8'h02);
    sym(K_DATA, 8'h20);      // dropped
    chk_reg("ovf_status", REG_STATUS, 8'h06);
    chk("ovf_flag", bus.rx_overflow, 1'b1);
    chk_reg("ovf_cnt_held", REG_FIFO_CNT, 8'd16);
    bus.rx_ready = 1'b1;
    push_data(8'h21);        // full but popping: accepted
    chk_reg("full_push_pop_cnt", REG_FIFO_CNT, 8'd16);
`ifdef CORE_RX_MON_STATS_EN
    chk_reg("sym_cnt_lo", REG_SYM_LO, 8'd17);
`else
    chk_reg("sym_cnt_absent", REG_SYM_LO, 8'h00);
`endif
    syms(K_IDLE, 20);
    chk_reg("drain_cnt", REG_FIFO_CNT, 8'd0);
    chk("drain_rx_valid", bus.rx_valid, 1'b0);
    chk("drain_sb_empty", 32'(sb_q.size()), 32'd0);

    // Clear + flush beat a same-cycle push
    bus.rx_ready = 1'b0;
    push_data(8'h30);
    push_data(8'h31);
    sym(K_ERR, 8'h00);
    chk_reg("pre_flush_err", REG_ERR_LO, 8'h01);
    wr_sym(REG_CTRL, 8'h03, K_DATA, 8'h55);
    sb_q.delete();
    chk("flush_rx_valid", bus.rx_valid, 1'b0);
    chk_reg("flush_cnt", REG_FIFO_CNT, 8'd0);
    chk_reg("flush_err_lo", REG_ERR_LO, 8'h00);
    chk_reg("flush_status", REG_STATUS, 8'h02);

    // Asynchronous reset with 5 entries buffered
    for (int i = 0; i < 5; i++) push_data(8'(8'h40 + i));
    chk_reg("pre_rst_cnt", REG_FIFO_CNT, 8'd5);
    #5;
    reset = 1'b1;
    #1;
    chk("async_rst_rx_valid", bus.rx_valid, 1'b0);
    chk("async_rst_link_up", bus.link_up, 1'b0);
    chk_reg("async_rst_status", REG_STATUS, 8'h00);
    sb_q.delete();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    repeat (2) @(posedge clock);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
